// File: rtl/index_gen_2d.sv
// Two-level (row x column) index generator with configurable strides,
// start/abort control and a valid/ready output handshake.
module index_gen_2d #(
    parameter int ROW_WIDTH = 16,
    parameter int COL_WIDTH = 10,
    parameter int ROW_INCR  = 1,
    parameter int COL_INCR  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ROW_WIDTH-1:0] num_rows,
    input  logic [COL_WIDTH-1:0] num_cols,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [ROW_WIDTH-1:0] row_idx,
    output logic [COL_WIDTH-1:0] col_idx,
    output logic                 last_col,
    output logic                 last_row,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ROW_WIDTH:0]   ROW_STEP_W = (ROW_WIDTH + 1)'(ROW_INCR);
    localparam logic [COL_WIDTH:0]   COL_STEP_W = (COL_WIDTH + 1)'(COL_INCR);
    localparam logic [ROW_WIDTH-1:0] ROW_STEP   = ROW_WIDTH'(ROW_INCR);
    localparam logic [COL_WIDTH-1:0] COL_STEP   = COL_WIDTH'(COL_INCR);

    state_t               state;
    logic [ROW_WIDTH-1:0] rows_q;
    logic [COL_WIDTH-1:0] cols_q;
    logic                 col_end;
    logic                 row_end;
    logic                 handshake;

    // One extra bit keeps idx + stride from wrapping past the latched count.
    assign col_end   = (({1'b0, col_idx} + COL_STEP_W) >= {1'b0, cols_q});
    assign row_end   = (({1'b0, row_idx} + ROW_STEP_W) >= {1'b0, rows_q});
    assign handshake = out_valid & out_ready;

    assign last_col = out_valid & col_end;
    assign last_row = out_valid & row_end;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            row_idx   <= '0;
            col_idx   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rows_q  <= num_rows;
                        cols_q  <= num_cols;
                        row_idx <= '0;
                        col_idx <= '0;
                        if ((num_rows == '0) || (num_cols == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (!col_end) begin
                            col_idx <= col_idx + COL_STEP;
                        end else begin
                            col_idx <= '0;
                            if (row_end) begin
                                state     <= DONE;
                                out_valid <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                row_idx <= row_idx + ROW_STEP;
                            end
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    row_idx <= '0;
                    col_idx <= '0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_index_gen_2d.sv
// Bench for index_gen_2d: queue-based beat model checked every cycle, plus
// directed sweeps with literal expectations on the collected beat log.
module tb_index_gen_2d;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, out_ready;
    logic [15:0] num_rows;
    logic [9:0]  num_cols;
    int          sel;

    logic start_a, start_b, start_c;
    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    logic        a_ov, a_lc, a_lr, a_busy, a_done;
    logic [15:0] a_row;
    logic [9:0]  a_col;
    logic        b_ov, b_lc, b_lr, b_busy, b_done;
    logic [15:0] b_row;
    logic [9:0]  b_col;
    logic        c_ov, c_lc, c_lr, c_busy, c_done;
    logic [15:0] c_row;
    logic [3:0]  c_col;

    index_gen_2d u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .num_rows(num_rows), .num_cols(num_cols), .out_ready(out_ready),
        .out_valid(a_ov), .row_idx(a_row), .col_idx(a_col),
        .last_col(a_lc), .last_row(a_lr), .busy(a_busy), .done(a_done)
    );

    index_gen_2d #(.ROW_INCR(2), .COL_INCR(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .num_rows(num_rows), .num_cols(num_cols), .out_ready(out_ready),
        .out_valid(b_ov), .row_idx(b_row), .col_idx(b_col),
        .last_col(b_lc), .last_row(b_lr), .busy(b_busy), .done(b_done)
    );

    index_gen_2d #(.COL_WIDTH(4), .COL_INCR(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort),
        .num_rows(num_rows), .num_cols(num_cols[3:0]), .out_ready(out_ready),
        .out_valid(c_ov), .row_idx(c_row), .col_idx(c_col),
        .last_col(c_lc), .last_row(c_lr), .busy(c_busy), .done(c_done)
    );

    logic        d_ov, d_lc, d_lr, d_busy, d_done;
    logic [15:0] d_row;
    logic [9:0]  d_col;

    always_comb begin
        d_ov = a_ov; d_lc = a_lc; d_lr = a_lr; d_busy = a_busy; d_done = a_done;
        d_row = a_row; d_col = a_col;
        if (sel == 1) begin
            d_ov = b_ov; d_lc = b_lc; d_lr = b_lr; d_busy = b_busy; d_done = b_done;
            d_row = b_row; d_col = b_col;
        end else if (sel == 2) begin
            d_ov = c_ov; d_lc = c_lc; d_lr = c_lr; d_busy = c_busy; d_done = c_done;
            d_row = c_row; d_col = {6'd0, c_col};
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the whole sweep is expanded into an ordered list of beats at start.
    typedef struct {
        int r;
        int c;
        bit lc;
        bit lr;
    } beat_t;

    beat_t q[$];
    bit    m_valid = 0, m_busy = 0, m_done = 0;
    bit    chk_en  = 0;

    function automatic void build(input int nr, input int nc, input int ri, input int ci);
        int last_r;
        last_r = -1;
        q.delete();
        for (int r = 0; r < nr; r += ri) begin
            for (int c = 0; c < nc; c += ci) begin
                beat_t b;
                b.r = r; b.c = c; b.lc = 1'b0; b.lr = 1'b0;
                q.push_back(b);
            end
            if (q.size() > 0) q[q.size()-1].lc = 1'b1;
            last_r = r;
        end
        foreach (q[i]) if (q[i].r == last_r) q[i].lr = 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n || abort) begin
            q.delete(); m_valid = 0; m_busy = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                build(int'(num_rows),
                      (sel == 2) ? int'(num_cols[3:0]) : int'(num_cols),
                      (sel == 1) ? 2 : 1,
                      (sel == 1) ? 4 : ((sel == 2) ? 2 : 1));
                m_busy = 1;
                if (q.size() == 0) m_done = 1;
                else m_valid = 1;
            end
        end else if (m_valid && out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_valid = 0; m_done = 1;
            end
        end
    end

    logic [31:0] beat_log[$];
    int          done_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("out_valid", {31'd0, d_ov}, {31'd0, m_valid});
            chk("busy", {31'd0, d_busy}, {31'd0, m_busy});
            chk("done", {31'd0, d_done}, {31'd0, m_done});
            if (m_valid && q.size() > 0) begin
                chk("row_idx", {16'd0, d_row}, q[0].r);
                chk("col_idx", {22'd0, d_col}, q[0].c);
                chk("last_col", {31'd0, d_lc}, {31'd0, q[0].lc});
                chk("last_row", {31'd0, d_lr}, {31'd0, q[0].lr});
            end else begin
                chk("last_col_idle", {31'd0, d_lc}, 0);
                chk("last_row_idle", {31'd0, d_lr}, 0);
            end
            if (!m_busy) begin
                chk("row_idle", {16'd0, d_row}, 0);
                chk("col_idle", {22'd0, d_col}, 0);
            end
            if (d_ov && out_ready) beat_log.push_back({d_row, 6'd0, d_col});
            if (d_done) done_cnt++;
        end
    end

    function automatic logic [31:0] rc(input int r, input int c);
        return {16'(r), 16'(c)};
    endfunction

    task automatic wait_done(input bit toggle, input int budget);
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            out_ready = toggle ? pat[i % 4] : 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        if (done_cnt == 0) chk("sweep_timeout", 0, 1);
    endtask

    task automatic run_sweep(input int nr, input int nc, input bit toggle, input int budget);
        beat_log.delete();
        done_cnt  = 0;
        num_rows  = 16'(nr);
        num_cols  = 10'(nc);
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        num_rows = 16'd7;
        num_cols = 10'd1;
        wait_done(toggle, budget);
    endtask

    task automatic go_to_beat6();
        beat_log.delete();
        done_cnt = 0;
        num_rows = 16'd3; num_cols = 10'd4; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_valid", {31'd0, d_ov}, 1);
        chk("mid_beat", {d_row, d_col[9:0] == 10'd2 ? 16'd2 : 16'({6'd0, d_col})}, rc(1, 2));
    endtask

    initial begin
        sel = 0; start = 0; abort = 0; out_ready = 1; num_rows = 0; num_cols = 0;
        rst_n = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        chk("rst_valid", {31'd0, d_ov}, 0);
        chk("rst_busy", {31'd0, d_busy}, 0);
        chk("rst_done", {31'd0, d_done}, 0);
        chk("rst_row", {16'd0, d_row}, 0);
        rst_n = 1;

        // Basic 3x4 sweep, always ready.
        run_sweep(3, 4, 1'b0, 100);
        chk("s1_beats", beat_log.size(), 12);
        chk("s1_b0", beat_log[0], rc(0, 0));
        chk("s1_b3", beat_log[3], rc(0, 3));
        chk("s1_b4", beat_log[4], rc(1, 0));
        chk("s1_b11", beat_log[11], rc(2, 3));
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_busy_after", {31'd0, d_busy}, 0);

        // Same sweep with ready 1,0,0,1,...
        run_sweep(3, 4, 1'b1, 200);
        chk("s2_beats", beat_log.size(), 12);
        for (int k = 0; k < 12 && k < beat_log.size(); k++)
            chk("s2_order", beat_log[k], rc(k / 4, k % 4));

        // Zero rows: done without any beat.
        done_cnt = 0;
        num_rows = 16'd0; num_cols = 10'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done", {31'd0, d_done}, 1);
        chk("zero_valid", {31'd0, d_ov}, 0);
        @(posedge clk); #1;
        chk("zero_done_end", {31'd0, d_done}, 0);
        chk("zero_busy", {31'd0, d_busy}, 0);

        // Strided: ROW_INCR=2, COL_INCR=4.
        sel = 1;
        run_sweep(5, 10, 1'b0, 100);
        chk("s4_beats", beat_log.size(), 9);
        chk("s4_b2", beat_log[2], rc(0, 8));
        chk("s4_b3", beat_log[3], rc(2, 0));
        chk("s4_b8", beat_log[8], rc(4, 8));

        // Narrow column counter near its top: COL_WIDTH=4, COL_INCR=2, 15 columns.
        sel = 2;
        run_sweep(2, 15, 1'b1, 200);
        chk("s5_beats", beat_log.size(), 16);
        chk("s5_b7", beat_log[7], rc(0, 14));
        chk("s5_b8", beat_log[8], rc(1, 0));

        // Abort mid-sweep at beat (1,2), then restart immediately.
        sel = 0;
        go_to_beat6();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_valid", {31'd0, d_ov}, 0);
        chk("ab_busy", {31'd0, d_busy}, 0);
        chk("ab_col", {22'd0, d_col}, 0);
        chk("ab_no_done", done_cnt, 0);
        start = 1'b1;
        beat_log.delete();
        @(posedge clk); #1;
        start = 1'b0;
        chk("ab_restart_valid", {31'd0, d_ov}, 1);
        chk("ab_restart_beat", {d_row, 6'd0, d_col}, rc(0, 0));
        wait_done(1'b0, 100);
        chk("ab_beats", beat_log.size(), 12);
        chk("ab_done_cnt", done_cnt, 1);

        // Reset mid-sweep instead of abort.
        go_to_beat6();
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rs_valid", {31'd0, d_ov}, 0);
        chk("rs_busy", {31'd0, d_busy}, 0);
        chk("rs_done", {31'd0, d_done}, 0);
        chk("rs_row", {16'd0, d_row}, 0);
        chk("rs_col", {22'd0, d_col}, 0);
        chk("rs_lc", {31'd0, d_lc}, 0);
        chk("rs_lr", {31'd0, d_lr}, 0);
        rst_n = 1'b1;
        run_sweep(2, 2, 1'b0, 50);
        chk("rs_beats", beat_log.size(), 4);
        chk("rs_b3", beat_log[3], rc(1, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
